// File: rtl/fb_rect_engine_pkg.sv
// Shared definitions for the rectangle fill engine: framebuffer geometry defaults,
// operation codes, FSM states and coordinate clamp helpers.
package fb_rect_engine_pkg;

  localparam int FB_W_DEFAULT = 320;
  localparam int FB_H_DEFAULT = 200;

  typedef enum logic [1:0] {
    OP_SET    = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_INVERT = 2'b10,
    OP_NOP    = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_WR_REQ  = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  function automatic logic [8:0] clamp_x(input logic [8:0] v, input logic [8:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [7:0] clamp_y(input logic [7:0] v, input logic [7:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/fb_rect_walker.sv
// Row-major coordinate stepper for a rectangle: loads (x0,y0) on start, advances
// one pixel per step, and flags the final pixel (x1,y1).
module fb_rect_walker
  import fb_rect_engine_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       step,
  input  logic [8:0] x0,
  input  logic [7:0] y0,
  input  logic [8:0] x1,
  input  logic [7:0] y1,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic       last
);

  assign last = (x == x1) && (y == y1);

  // Position register: load origin, then wrap x back to x0 at the end of each row
  always_ff @(posedge clk) begin
    if (reset) begin
      x <= 9'd0;
      y <= 8'd0;
    end else if (start) begin
      x <= x0;
      y <= y0;
    end else if (step) begin
      if (x == x1) begin
        x <= x0;
        y <= y + 8'd1;
      end else begin
        x <= x + 9'd1;
      end
    end
  end

endmodule

// File: rtl/fb_rect_engine.sv
// Rectangle fill engine driving framebuffer port B with SET, CLEAR or INVERT
// (read-modify-write), one command at a time.
module fb_rect_engine
  import fb_rect_engine_pkg::*;
#(
  parameter int FB_W = FB_W_DEFAULT,
  parameter int FB_H = FB_H_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_x0,
  input  logic [7:0]  cmd_y0,
  input  logic [8:0]  cmd_x1,
  input  logic [7:0]  cmd_y1,
  input  logic [1:0]  cmd_op,
  output logic        busy,
  output logic        done,
  output logic [16:0] pix_cnt,
  output logic [8:0]  fb_x,
  output logic [7:0]  fb_y,
  output logic        fb_read,
  output logic        fb_write,
  output logic        fb_din,
  input  logic        fb_dout,
  input  logic        fb_rdy
);

  localparam logic [8:0] X_MAX = 9'(FB_W - 1);
  localparam logic [7:0] Y_MAX = 8'(FB_H - 1);

  state_e     state;
  state_e     state_nxt;
  op_e        op;
  logic [8:0] x0;
  logic [8:0] x1;
  logic [7:0] y0;
  logic [7:0] y1;
  logic       rd_first;
  logic [8:0] x1_clip;
  logic [7:0] y1_clip;
  logic       empty;
  logic       walk_start;
  logic       walk_step;
  logic       walk_last;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  // Clip the far corner to the screen and detect commands that touch no pixel
  always_comb begin
    x1_clip = clamp_x(x1, X_MAX);
    y1_clip = clamp_y(y1, Y_MAX);
    empty   = (x0 > X_MAX) || (y0 > Y_MAX) || (x0 > x1_clip) || (y0 > y1_clip) || (op == OP_NOP);
  end

  fb_rect_walker u_walker (
    .clk   (clk),
    .reset (reset),
    .start (walk_start),
    .step  (walk_step),
    .x0    (x0),
    .y0    (y0),
    .x1    (x1),
    .y1    (y1),
    .x     (fb_x),
    .y     (fb_y),
    .last  (walk_last)
  );

  // Next-state and request decode; requests only ever assert while fb_rdy is high
  always_comb begin
    state_nxt  = state;
    fb_read    = 1'b0;
    fb_write   = 1'b0;
    walk_start = 1'b0;
    walk_step  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) state_nxt = ST_SETUP;
        else           state_nxt = ST_IDLE;
      end
      ST_SETUP: begin
        walk_start = 1'b1;
        if (empty)                 state_nxt = ST_DONE;
        else if (op == OP_INVERT)  state_nxt = ST_RD_REQ;
        else                       state_nxt = ST_WR_REQ;
      end
      ST_RD_REQ: begin
        fb_read = fb_rdy;
        if (fb_rdy) state_nxt = ST_RD_WAIT;
        else        state_nxt = ST_RD_REQ;
      end
      ST_RD_WAIT: begin
        // The cycle right after the read issue never carries the result
        if (!rd_first && fb_rdy) state_nxt = ST_WR_REQ;
        else                     state_nxt = ST_RD_WAIT;
      end
      ST_WR_REQ: begin
        fb_write = fb_rdy;
        if (!fb_rdy) begin
          state_nxt = ST_WR_REQ;
        end else if (walk_last) begin
          state_nxt = ST_DONE;
        end else begin
          walk_step = 1'b1;
          state_nxt = (op == OP_INVERT) ? ST_RD_REQ : ST_WR_REQ;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register, command latch, write data and pixel counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op       <= OP_NOP;
      x0       <= 9'd0;
      x1       <= 9'd0;
      y0       <= 8'd0;
      y1       <= 8'd0;
      rd_first <= 1'b0;
      fb_din   <= 1'b0;
      pix_cnt  <= 17'd0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            x0 <= cmd_x0;
            y0 <= cmd_y0;
            x1 <= cmd_x1;
            y1 <= cmd_y1;
            op <= op_e'(cmd_op);
          end
        end
        ST_SETUP: begin
          x1      <= x1_clip;
          y1      <= y1_clip;
          pix_cnt <= 17'd0;
          fb_din  <= (op == OP_SET);
        end
        ST_RD_REQ: begin
          if (fb_rdy) rd_first <= 1'b1;
        end
        ST_RD_WAIT: begin
          rd_first <= 1'b0;
          if (!rd_first && fb_rdy) fb_din <= ~fb_dout;
        end
        ST_WR_REQ: begin
          if (fb_rdy) pix_cnt <= pix_cnt + 17'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
